// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM
// state codes and a two's-complement magnitude helper.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] MUL  = 3'd1;
    localparam logic [2:0] DIV  = 3'd2;
    localparam logic [2:0] ZERO = 3'd3;
    localparam logic [2:0] FIX  = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    // Callers zero-extend their operand and cast the result back to their own
    // width; the low bits of the negation are correct for any width up to ABS_W.
    localparam int ABS_W = 64;

    function automatic logic [ABS_W-1:0] abs_2c(input logic [ABS_W-1:0] value,
                                                input logic             negative);
        return negative ? (~value + 64'd1) : value;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the shared datapath: a shift-add step for
// multiply (mode=0) or a restoring-division step (mode=1).
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             mode,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] operand,
    input  logic             in_bit,
    output logic [WIDTH-1:0] next_acc,
    output logic             out_bit
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    // For divide, the partial remainder is always below the divisor, so a
    // non-negative difference never exceeds WIDTH bits.
    always_comb begin
        sum      = {1'b0, acc} + {1'b0, (in_bit ? operand : '0)};
        shifted  = {acc, in_bit};
        diff     = {1'b0, shifted} - {2'b00, operand};
        next_acc = sum[WIDTH:1];
        out_bit  = sum[0];
        if (mode) begin
            if (diff[WIDTH+1:WIDTH] == 2'b00) begin
                next_acc = diff[WIDTH-1:0];
                out_bit  = 1'b1;
            end else begin
                next_acc = shifted[WIDTH-1:0];
                out_bit  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide unit with start/busy/done handshake.
// Optional build macro: MULDIV_EARLY_TERM_EN (multiply stops once the remaining multiplier bits are zero).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [2:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   opnd;
    logic               is_div_r;
    logic               neg_lo;
    logic               neg_hi;

    logic               op_div;
    logic               op_signed;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic               last_iter;
    logic               step_in;
    logic [WIDTH-1:0]   step_acc;
    logic               step_bit;
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

`ifdef MULDIV_EARLY_TERM_EN
    logic [WIDTH-1:0]   mrem;
    logic [CNT_W-1:0]   rem_shift;
`endif

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Multiply consumes the multiplier from lo[0] upward; divide feeds the
    // dividend in from lo[MSB] while the quotient shifts in at lo[0].
    assign step_in = is_div_r ? lo[WIDTH-1] : lo[0];

    muldiv_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .mode     (is_div_r),
        .acc      (hi),
        .operand  (opnd),
        .in_bit   (step_in),
        .next_acc (step_acc),
        .out_bit  (step_bit)
    );

    always_comb begin
        op_div    = (op == OP_DIV)  || (op == OP_DIVU);
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        sa        = op_signed & a[WIDTH-1];
        sb        = op_signed & b[WIDTH-1];
        a_abs     = WIDTH'(abs_2c(ABS_W'(a), sa));
        b_abs     = WIDTH'(abs_2c(ABS_W'(b), sb));
    end

`ifdef MULDIV_EARLY_TERM_EN
    // An early-terminated product sits left-aligned by the skipped iterations.
    always_comb begin
        last_iter = (cnt == CNT_W'(WIDTH - 1)) ||
                    ((state == MUL) && ((mrem >> 1) == '0));
        rem_shift = CNT_W'(WIDTH) - cnt;
        prod_raw  = {hi, lo} >> rem_shift;
    end
`else
    always_comb begin
        last_iter = (cnt == CNT_W'(WIDTH - 1));
        prod_raw  = {hi, lo};
    end
`endif

    always_comb begin
        prod_fix = neg_lo ? -prod_raw : prod_raw;
        quo_fix  = neg_lo ? -lo : lo;
        rem_fix  = neg_hi ? -hi : hi;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            is_div_r <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
`ifdef MULDIV_EARLY_TERM_EN
            mrem     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        div_zero <= 1'b0;
                        is_div_r <= op_div;
                        neg_lo   <= sa ^ sb;
                        neg_hi   <= op_div ? sa : (sa ^ sb);
                        cnt      <= '0;
                        // A zero divisor leaves hi/lo untouched.
                        if (op_div && (b == '0)) begin
                            state <= ZERO;
                        end else if (op_div) begin
                            hi    <= '0;
                            lo    <= a_abs;
                            opnd  <= b_abs;
                            state <= DIV;
                        end else begin
                            hi    <= '0;
                            lo    <= b_abs;
                            opnd  <= a_abs;
`ifdef MULDIV_EARLY_TERM_EN
                            mrem  <= b_abs;
`endif
                            state <= MUL;
                        end
                    end
                end
                MUL, DIV: begin
                    hi  <= step_acc;
                    lo  <= is_div_r ? {lo[WIDTH-2:0], step_bit} : {step_bit, lo[WIDTH-1:1]};
                    cnt <= cnt + CNT_W'(1);
`ifdef MULDIV_EARLY_TERM_EN
                    mrem <= mrem >> 1;
`endif
                    if (last_iter) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div_r) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    state <= DONE;
                end
                ZERO: begin
                    div_zero <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32; multiply latencies
// follow MULDIV_EARLY_TERM_EN when the bench is built with it.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    int lat;

    muldiv_unit #(
        .WIDTH    (32)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Expected multiply latency for a multiplier magnitude.
    function automatic int mul_lat(input logic [31:0] mag);
        int h;
        h = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) h = i;
`ifdef MULDIV_EARLY_TERM_EN
        return h + 3;
`else
        return (h < 32) ? 34 : 0;
`endif
    endfunction

    // Leaves the bench 1 time unit after the start-sampling edge.
    task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] x,
                                  input logic [31:0] y);
        @(negedge clock);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int from, output int cycles);
        cycles = from;
        while (!done && cycles < 100) begin
            @(posedge clock);
            #1;
            cycles++;
        end
    endtask

    task automatic finish_op(input string tag, input int got_lat, input int exp_lat,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                             input logic exp_dz);
        check_output({tag, " latency"}, 64'(got_lat), 64'(exp_lat));
        check_output({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check_output({tag, " lo"}, 64'(lo), 64'(exp_lo));
        check_output({tag, " div_zero"}, 64'(div_zero), 64'(exp_dz));
        check_output({tag, " busy_at_done"}, 64'(busy), 64'd1);
        @(posedge clock);
        #1;
        check_output({tag, " done_drop"}, 64'({done, busy}), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int exp_lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz);
        int n;
        apply_stimulus(o, x, y);
        wait_done(1, n);
        finish_op(tag, n, exp_lat, exp_hi, exp_lo, exp_dz);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = OP_MULT;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clock);
        #1;
        check_output("reset busy", 64'(busy), 64'd0);
        check_output("reset done", 64'(done), 64'd0);
        check_output("reset div_zero", 64'(div_zero), 64'd0);
        check_output("reset hi", 64'(hi), 64'd0);
        check_output("reset lo", 64'(lo), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        run_op("mult -3*7", OP_MULT, 32'hFFFF_FFFD, 32'd7, mul_lat(32'd7),
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("multu max*max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               mul_lat(32'hFFFF_FFFF), 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 34,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu 7/2", OP_DIVU, 32'd7, 32'd2, 34, 32'd1, 32'd3, 1'b0);
        run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 34,
               32'd1, 32'hFFFF_FFFD, 1'b0);
        run_op("div overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34,
               32'd0, 32'h8000_0000, 1'b0);
        run_op("divu preload", OP_DIVU, 32'h5555_AAAA, 32'h0001_0000, 34,
               32'h0000_AAAA, 32'h0000_5555, 1'b0);
        run_op("div by zero", OP_DIV, 32'd5, 32'd0, 2,
               32'h0000_AAAA, 32'h0000_5555, 1'b1);
        check_output("div_zero held", 64'(div_zero), 64'd1);

        apply_stimulus(OP_MULTU, 32'd3, 32'd4);
        check_output("div_zero cleared", 64'(div_zero), 64'd0);
        wait_done(1, lat);
        finish_op("multu 3*4", lat, mul_lat(32'd4), 32'd0, 32'd12, 1'b0);

        // Start raised during DONE must be dropped, not queued.
        apply_stimulus(OP_MULTU, 32'd9, 32'd3);
        wait_done(1, lat);
        check_output("multu 9*3 latency", 64'(lat), 64'(mul_lat(32'd3)));
        check_output("multu 9*3 lo", 64'(lo), 64'd27);
        @(negedge clock);
        op    = OP_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check_output("start in done ignored", 64'(busy), 64'd0);
        check_output("result kept after done", 64'({hi, lo}), 64'd27);

        apply_stimulus(OP_MULT, 32'd6, 32'hFFFF_FFFB);
        lat = 1;
        @(posedge clock);
        #1;
        lat = 2;
        check_output("busy mid mult", 64'(busy), 64'd1);
        @(negedge clock);
        op    = OP_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        @(posedge clock);
        #1;
        lat   = 3;
        start = 1'b0;
        wait_done(lat, lat);
        finish_op("mult ignore restart", lat, mul_lat(32'd5),
                  32'hFFFF_FFFF, 32'hFFFF_FFE2, 1'b0);

        run_op("mult by zero", OP_MULT, 32'h7FFF_FFFF, 32'd0, mul_lat(32'd0),
               32'd0, 32'd0, 1'b0);

        apply_stimulus(OP_DIVU, 32'd100, 32'd7);
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_output("abort busy", 64'(busy), 64'd0);
        check_output("abort done", 64'(done), 64'd0);
        check_output("abort div_zero", 64'(div_zero), 64'd0);
        check_output("abort hi/lo", 64'({hi, lo}), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
